// File: rtl/dma_arbiter.sv
// Round-robin arbiter sharing one DMA engine among NUM_REQ requesters.
// Optional transfer watchdog: define DMA_ARB_TIMEOUT_EN to abort a stalled WAIT with err.
module dma_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_src,
    input  logic [NUM_REQ*ADDR_W-1:0] req_dst,
    input  logic [NUM_REQ*ADDR_W-1:0] req_amt,
    output logic [NUM_REQ-1:0]        grant,
    output logic [NUM_REQ-1:0]        cmp,
    output logic [NUM_REQ-1:0]        err,
    output logic                      busy,
    output logic                      dma_start,
    output logic [ADDR_W-1:0]         dma_src,
    output logic [ADDR_W-1:0]         dma_dst,
    output logic [ADDR_W-1:0]         dma_amt,
    input  logic                      dma_done
);
    localparam int OW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FINISH} state_t;
    typedef struct packed {
        logic [ADDR_W-1:0] src;
        logic [ADDR_W-1:0] dst;
        logic [ADDR_W-1:0] amt;
    } desc_t;

    state_t              state;
    desc_t [NUM_REQ-1:0] desc;
    logic [OW-1:0]       owner;
    logic [OW-1:0]       last_owner;
    logic [OW-1:0]       winner;
    logic                found;
    logic                skip;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_desc
        assign desc[i].src = req_src[i*ADDR_W +: ADDR_W];
        assign desc[i].dst = req_dst[i*ADDR_W +: ADDR_W];
        assign desc[i].amt = req_amt[i*ADDR_W +: ADDR_W];
    end

    function automatic logic [NUM_REQ-1:0] onehot(input logic [OW-1:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

    // Search starts just past the previous owner, so the owner itself is checked last.
    always_comb begin
        int idx;
        winner = last_owner;
        found  = 1'b0;
        idx    = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = int'(last_owner) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && req[OW'(idx)]) begin
                found  = 1'b1;
                winner = OW'(idx);
            end
        end
    end

`ifdef DMA_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0]      cnt;
    logic [NUM_REQ-1:0] err_r;
    assign err = err_r;
`else
    assign err = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= '0;
            last_owner <= OW'(NUM_REQ - 1);
            skip       <= 1'b0;
            grant      <= '0;
            cmp        <= '0;
            busy       <= 1'b0;
            dma_start  <= 1'b0;
            dma_src    <= '0;
            dma_dst    <= '0;
            dma_amt    <= '0;
`ifdef DMA_ARB_TIMEOUT_EN
            err_r      <= '0;
            cnt        <= '0;
`endif
        end else begin
            grant     <= '0;
            cmp       <= '0;
            dma_start <= 1'b0;
`ifdef DMA_ARB_TIMEOUT_EN
            err_r     <= '0;
`endif
            case (state)
                IDLE: begin
                    if (found) begin
                        owner   <= winner;
                        grant   <= onehot(winner);
                        dma_src <= desc[winner].src;
                        dma_dst <= desc[winner].dst;
                        dma_amt <= desc[winner].amt;
                        busy    <= 1'b1;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Zero-length transfers never touch the engine.
                    if (dma_amt == '0) begin
                        skip  <= 1'b1;
                        state <= FINISH;
                    end else begin
                        skip      <= 1'b0;
                        dma_start <= 1'b1;
                        state     <= WAIT;
`ifdef DMA_ARB_TIMEOUT_EN
                        cnt       <= '0;
`endif
                    end
                end
                WAIT: begin
                    if (dma_done) begin
                        cmp   <= onehot(owner);
                        state <= FINISH;
                    end
`ifdef DMA_ARB_TIMEOUT_EN
                    else if (cnt == CW'(TIMEOUT - 1)) begin
                        err_r <= onehot(owner);
                        state <= FINISH;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
`endif
                end
                FINISH: begin
                    // Engine completions already reported on entry; only the skipped path reports here.
                    if (skip) cmp <= onehot(owner);
                    last_owner <= owner;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dma_arbiter.sv
// Scoreboard bench for dma_arbiter: directed transfers with hand-computed event cycles.
module tb_dma_arbiter;
    localparam int NR = 4, AW = 32, TO = 16;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [NR-1:0]          req = '0;
    logic [NR-1:0][AW-1:0]  s_a = '0, d_a = '0, a_a = '0;
    logic                   dma_done = 1'b0;
    logic [NR-1:0]          grant, cmp, err;
    logic                   busy, dma_start;
    logic [AW-1:0]          dma_src, dma_dst, dma_amt;

    int cyc = 0, tests = 0, fails = 0, done_delay = 0;

    typedef struct {
        int            c;
        logic [NR-1:0] g, m, e;
        logic          s;
        logic [AW-1:0] src, dst, amt;
    } ev_t;
    ev_t q[$];

    dma_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req(req),
        .req_src(s_a), .req_dst(d_a), .req_amt(a_a),
        .grant(grant), .cmp(cmp), .err(err), .busy(busy), .dma_start(dma_start),
        .dma_src(dma_src), .dma_dst(dma_dst), .dma_amt(dma_amt), .dma_done(dma_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [NR-1:0] oh(input int i);
        return NR'(1) << i;
    endfunction

    task automatic tick(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, want %0h", nm, got, exp);
        end
    endtask

    task automatic push(input int c, input logic [NR-1:0] g, input logic [NR-1:0] m,
                        input logic [NR-1:0] e, input logic s, input int id);
        ev_t x;
        x.c = c; x.g = g; x.m = m; x.e = e; x.s = s;
        x.src = s_a[2'(id)]; x.dst = d_a[2'(id)]; x.amt = a_a[2'(id)];
        q.push_back(x);
    endtask

    // Grant at g; start at g+1; cmp one cycle after dma_done, or at g+2 for zero length.
    task automatic expect_xfer(input int g, input int id, input int dd);
        push(g, oh(id), '0, '0, 1'b0, id);
        if (a_a[2'(id)] == '0) push(g + 2, '0, oh(id), '0, 1'b0, id);
        else begin
            push(g + 1, '0, '0, '0, 1'b1, id);
            if (dd > 0) push(g + 2 + dd, '0, oh(id), '0, 1'b0, id);
        end
    endtask

    task automatic set_desc(input int i, input logic [AW-1:0] s, input logic [AW-1:0] d,
                            input logic [AW-1:0] a);
        s_a[2'(i)] = s; d_a[2'(i)] = d; a_a[2'(i)] = a;
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((busy || q.size() != 0) && k < 200) begin
            tick(1);
            k++;
        end
        tests++;
        if (busy || q.size() != 0) begin
            fails++;
            $display("FAIL drain: busy=%0b pending=%0d, want busy=0 pending=0", busy, q.size());
        end
        tick(2);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        tick(2);
        rst = 1'b0;
        tick(1);
    endtask

    // Engine model: answers each dma_start after done_delay cycles (0 = never).
    initial forever begin
        @(posedge clk);
        #1;
        if (dma_start && done_delay > 0) begin
            repeat (done_delay) @(posedge clk);
            #1;
            dma_done = 1'b1;
            @(posedge clk);
            #1;
            dma_done = 1'b0;
        end
    end

    // Monitor: every output pulse must match the head of the scoreboard.
    initial forever begin
        @(negedge clk);
        if (!rst && (((grant | cmp | err) != '0) || dma_start)) begin
            ev_t x;
            tests++;
            if (!$onehot0(grant) || !$onehot0(cmp) || !$onehot0(err) || (grant & cmp) != '0) begin
                fails++;
                $display("FAIL onehot: cyc=%0d grant=%b cmp=%b err=%b, want one-hot0 and no overlap",
                         cyc, grant, cmp, err);
            end
            tests++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_event: cyc=%0d grant=%b cmp=%b err=%b start=%b, want none",
                         cyc, grant, cmp, err, dma_start);
            end else begin
                x = q.pop_front();
                if (cyc != x.c || grant !== x.g || cmp !== x.m || err !== x.e || dma_start !== x.s ||
                    dma_src !== x.src || dma_dst !== x.dst || dma_amt !== x.amt) begin
                    fails++;
                    $display("FAIL event: got cyc=%0d g=%b c=%b e=%b s=%b src=%h dst=%h amt=%h, want cyc=%0d g=%b c=%b e=%b s=%b src=%h dst=%h amt=%h",
                             cyc, grant, cmp, err, dma_start, dma_src, dma_dst, dma_amt,
                             x.c, x.g, x.m, x.e, x.s, x.src, x.dst, x.amt);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        tick(2);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_grant", 64'(grant), 64'd0);
        chk("rst_start", 64'(dma_start), 64'd0);
        chk("rst_src", 64'(dma_src), 64'd0);
        chk("rst_amt", 64'(dma_amt), 64'd0);
        rst = 1'b0;
        tick(1);

        // Single transfer from requester 0
        set_desc(0, 32'h100, 32'h200, 32'd8);
        done_delay = 5;
        n = cyc;
        req = 4'b0001;
        expect_xfer(n + 1, 0, 5);
        tick(1);
        req = '0;
        chk("busy_after_grant", 64'(busy), 64'd1);
        wait_idle();

        // All four held: strict rotation 0,1,2,3,0
        do_reset();
        for (int i = 0; i < NR; i++) set_desc(i, 32'h1000 + 32'(i * 16), 32'h2000 + 32'(i * 16), 32'(i + 1));
        done_delay = 3;
        n = cyc;
        req = 4'b1111;
        expect_xfer(n + 1, 0, 3);
        expect_xfer(n + 8, 1, 3);
        expect_xfer(n + 15, 2, 3);
        expect_xfer(n + 22, 3, 3);
        expect_xfer(n + 29, 0, 3);
        while (cyc < n + 29) tick(1);
        req = '0;
        wait_idle();

        // Zero-length transfer skips the engine
        set_desc(2, 32'h300, 32'h400, 32'd0);
        n = cyc;
        req = 4'b0100;
        expect_xfer(n + 1, 2, 0);
        tick(1);
        req = '0;
        wait_idle();

        // Request from 3 withdrawn while 0 is busy
        set_desc(0, 32'h700, 32'h800, 32'd4);
        set_desc(3, 32'h900, 32'hA00, 32'd6);
        done_delay = 5;
        n = cyc;
        req = 4'b0001;
        expect_xfer(n + 1, 0, 5);
        tick(1);
        req = '0;
        tick(2);
        req = 4'b1000;
        tick(3);
        req = '0;
        wait_idle();
        tick(5);
        chk("withdraw_idle", 64'(busy), 64'd0);

        // Reset in WAIT aborts silently; next arbitration favours requester 1 over 3
        set_desc(1, 32'hB00, 32'hC00, 32'd5);
        done_delay = 0;
        n = cyc;
        req = 4'b0010;
        expect_xfer(n + 1, 1, 0);
        tick(1);
        req = '0;
        tick(3);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_start", 64'(dma_start), 64'd0);
        chk("midrst_src", 64'(dma_src), 64'd0);
        chk("midrst_dst", 64'(dma_dst), 64'd0);
        chk("midrst_amt", 64'(dma_amt), 64'd0);
        chk("midrst_pending", 64'(q.size()), 64'd0);
        tick(2);
        rst = 1'b0;
        tick(1);
        set_desc(1, 32'hD00, 32'hE00, 32'd3);
        done_delay = 2;
        n = cyc;
        req = 4'b1010;
        expect_xfer(n + 1, 1, 2);
        tick(1);
        req = '0;
        wait_idle();

        // Engine never answers
        set_desc(0, 32'h500, 32'h600, 32'd7);
        done_delay = 0;
        n = cyc;
        req = 4'b0001;
        expect_xfer(n + 1, 0, 0);
`ifdef DMA_ARB_TIMEOUT_EN
        push(n + 2 + TO, '0, '0, oh(0), 1'b0, 0);
        tick(1);
        req = '0;
        wait_idle();
`else
        tick(1);
        req = '0;
        tick(40);
        chk("hang_busy", 64'(busy), 64'd1);
        chk("hang_err", 64'(err), 64'd0);
        do_reset();
`endif
        chk("final_pending", 64'(q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/dma_arbiter.md
DMA_ARBITER -- requirements
Module: dma_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing the DMA engine (2..8).
REQ-002 Parameter ADDR_W, default 32, width of source/destination address and element count.
REQ-003 Parameter TIMEOUT, default 1024, cycles allowed between dma_start and dma_done (used only under DMA_ARB_TIMEOUT_EN).
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 req  input  NUM_REQ  per-requester transfer request level; held until grant.
REQ-007 req_src  input  NUM_REQ*ADDR_W  flattened source addresses, requester i at bits [i*ADDR_W +: ADDR_W].
REQ-008 req_dst  input  NUM_REQ*ADDR_W  flattened destination addresses, same packing.
REQ-009 req_amt  input  NUM_REQ*ADDR_W  flattened element counts, same packing.
REQ-010 grant  output  NUM_REQ  one-hot, one-cycle pulse: request accepted, descriptor latched.
REQ-011 cmp  output  NUM_REQ  one-hot, one-cycle pulse: owner's transfer finished.
REQ-012 err  output  NUM_REQ  one-hot, one-cycle pulse: owner's transfer aborted by timeout.
REQ-013 busy  output  1  high whenever state is not IDLE.
REQ-014 dma_start  output  1  one-cycle start pulse to DMA engine.
REQ-015 dma_src / dma_dst / dma_amt  output  ADDR_W each  latched descriptor, stable from grant until return to IDLE.
REQ-016 dma_done  input  1  DMA engine completion pulse.

Function
REQ-017 FSM states: IDLE, ISSUE, WAIT, FINISH; all outputs registered.
REQ-018 IDLE: if any req bit set, select winner round-robin, searching upward from (last_owner+1) mod NUM_REQ with wrap-around; latch winner's src/dst/amt; pulse grant[winner]; go ISSUE next cycle.
REQ-019 Request sampled in cycle N produces grant in cycle N+1 and dma_start in cycle N+2.
REQ-020 ISSUE: if latched amt == 0, skip DMA (no dma_start), go FINISH; else pulse dma_start, go WAIT.
REQ-021 WAIT: on dma_done go FINISH; dma_done seen in any other state is ignored.
REQ-022 FINISH: pulse cmp[owner] (or err[owner] on timeout), update last_owner = owner, return to IDLE; next arbitration occurs in the IDLE cycle after.
REQ-023 Requests arriving while busy are not granted until IDLE; req deassertion before grant withdraws the request with no side effects.
REQ-024 Owner's own req still high at IDLE is considered only after all other pending requesters (round-robin fairness); single requester may be re-granted back-to-back.
REQ-025 At most one grant, cmp, err and dma_start bit high in any cycle; grant and cmp for the same requester never coincide.

Reset
REQ-026 rst asserted at any time, including mid-transfer, forces state IDLE, last_owner = NUM_REQ-1, and all outputs (grant, cmp, err, busy, dma_start, dma_src, dma_dst, dma_amt) to 0 asynchronously; no cmp is issued for an aborted transfer.
REQ-027 First arbitration after reset favours requester 0.

Configuration
REQ-028 Macro DMA_ARB_TIMEOUT_EN defined: WAIT counts cycles from dma_start; reaching TIMEOUT without dma_done goes FINISH with err[owner] pulsed instead of cmp[owner]; dma_done in the same cycle as expiry counts as completion (cmp wins).
REQ-029 Macro not defined: no counter is built, WAIT lasts indefinitely, err is constant 0.

Verification
REQ-030 Reset then req=4'b0001, src=0x100, dst=0x200, amt=8; dma_done 5 cycles after dma_start -> grant=0001 at N+1, dma_start at N+2, dma_src=0x100, dma_dst=0x200, dma_amt=8, cmp=0001 one cycle after dma_done.
REQ-031 req=4'b1111 held, dma_done 3 cycles after every start -> grant order 0,1,2,3,0; no requester granted twice before others.
REQ-032 req[2] with amt=0 -> grant=0100, no dma_start, cmp=0100 two cycles after grant.
REQ-033 rst pulsed in WAIT for req[1] -> busy=0 and all outputs 0 immediately; no cmp; next req=4'b1010 grants requester 1.
REQ-034 With DMA_ARB_TIMEOUT_EN, TIMEOUT=16, dma_done never asserted -> err[owner] pulsed 16 cycles after dma_start, then IDLE; without macro -> busy stays 1.
REQ-035 req[3] asserted while requester 0 busy, then deasserted before FINISH -> requester 3 never granted, no stray pulses.
